des_iter_ctrl: RTL and testbench

Sequencer for an iterative DES core: one shared round datapath (f-block, key-schedule rotate, PC-2) is reused for all 16 rounds instead of 16 unrolled stages. The controller accepts a plaintext/key pair through a valid/ready handshake and pulses the datapath load, round and final-permutation enables. It also issues the per-round key-schedule rotation amount and direction, for encrypt or decrypt, and holds the result until the consumer takes it. It sits between the upstream block source and the DES datapath registers (L/R, C/D, output register).

---
 rtl/des_iter_ctrl.sv | 147 ++++++++++++++
 tb/tb_des_iter_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/des_iter_ctrl.sv
// Sequencer for an iterative DES core. One shared round datapath is reused for all
// rounds. This block issues the load, round and final enables and the key-schedule rotations.
module des_iter_ctrl #(
  parameter int ROUNDS = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic       DECRYPT,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       DP_LOAD,
  output logic       DP_ROUND,
  output logic [3:0] DP_ROUND_IDX,
  output logic [1:0] KS_SHIFT,
  output logic       KS_DIR,
  output logic       DP_FINAL,
  output logic       BUSY,
  output logic [2:0] DBG_STATE
);

  // Handshakes: a block is taken on the edge where IN_VALID & IN_READY. A result is
  // released on the edge where OUT_VALID & OUT_READY. Once a valid is raised, it is not
  // withdrawn by the side that raised it.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mode_q, mode_d;

  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       dp_load_q, dp_load_d;
  logic       dp_round_q, dp_round_d;
  logic [3:0] dp_round_idx_q, dp_round_idx_d;
  logic [1:0] ks_shift_q, ks_shift_d;
  logic       ks_dir_q, ks_dir_d;
  logic       dp_final_q, dp_final_d;
  logic       busy_q, busy_d;

  // Decrypt skips the rotation for round 0 because C/D after PC-1 already equal C16/D16.
  function automatic logic [1:0] shift_of(input logic [3:0] idx, input logic dec);
    if (dec && idx == 4'd0) return 2'd0;
    if (idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15) return 2'd1;
    return 2'd2;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          mode_d  = DECRYPT;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = 4'd0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (cnt_q == LAST_IDX) begin
          cnt_d   = 4'd0;
          state_d = S_FINAL;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_FINAL: state_d = S_HOLD;
      S_HOLD: begin
        if (OUT_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so each one lines up with its state cycle.
  always_comb begin
    in_ready_d     = (state_d == S_IDLE);
    busy_d         = (state_d != S_IDLE);
    dp_load_d      = (state_d == S_LOAD);
    dp_round_d     = (state_d == S_ROUND);
    dp_final_d     = (state_d == S_FINAL);
    out_valid_d    = (state_d == S_HOLD);
    dp_round_idx_d = 4'd0;
    ks_shift_d     = 2'd0;
    ks_dir_d       = (state_d != S_IDLE) ? mode_d : 1'b0;
    if (state_d == S_ROUND) begin
      dp_round_idx_d = cnt_d;
      ks_shift_d     = shift_of(cnt_d, mode_d);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      cnt_q          <= 4'd0;
      mode_q         <= 1'b0;
      in_ready_q     <= 1'b1;
      busy_q         <= 1'b0;
      dp_load_q      <= 1'b0;
      dp_round_q     <= 1'b0;
      dp_final_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      dp_round_idx_q <= 4'd0;
      ks_shift_q     <= 2'd0;
      ks_dir_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mode_q         <= mode_d;
      in_ready_q     <= in_ready_d;
      busy_q         <= busy_d;
      dp_load_q      <= dp_load_d;
      dp_round_q     <= dp_round_d;
      dp_final_q     <= dp_final_d;
      out_valid_q    <= out_valid_d;
      dp_round_idx_q <= dp_round_idx_d;
      ks_shift_q     <= ks_shift_d;
      ks_dir_q       <= ks_dir_d;
    end
  end

  assign IN_READY     = in_ready_q;
  assign BUSY         = busy_q;
  assign DP_LOAD      = dp_load_q;
  assign DP_ROUND     = dp_round_q;
  assign DP_FINAL     = dp_final_q;
  assign OUT_VALID    = out_valid_q;
  assign DP_ROUND_IDX = dp_round_idx_q;
  assign KS_SHIFT     = ks_shift_q;
  assign KS_DIR       = ks_dir_q;
  assign DBG_STATE    = state_q;

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Bench for des_iter_ctrl: directed blocks push expected control events into a queue,
// and a negedge monitor pops and compares them whenever the controller emits one.
module tb_des_iter_ctrl;
  localparam int ROUNDS = 16;

  logic       CLK = 1'b0;
  logic       RST, IN_VALID, DECRYPT, OUT_READY;
  logic       IN_READY, OUT_VALID, DP_LOAD, DP_ROUND, KS_DIR, DP_FINAL, BUSY;
  logic [3:0] DP_ROUND_IDX;
  logic [1:0] KS_SHIFT;
  logic [2:0] DBG_STATE;

  des_iter_ctrl #(.ROUNDS(ROUNDS)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .DECRYPT(DECRYPT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .DP_LOAD(DP_LOAD), .DP_ROUND(DP_ROUND),
    .DP_ROUND_IDX(DP_ROUND_IDX), .KS_SHIFT(KS_SHIFT), .KS_DIR(KS_DIR), .DP_FINAL(DP_FINAL),
    .BUSY(BUSY), .DBG_STATE(DBG_STATE)
  );

  // Clock and reset
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  // Event word: {cycle[5:0], load, round, final, out_valid_rise, idx[3:0], shift[1:0], dir}
  logic [16:0] exp_q[$];
  logic [16:0] mon_act;
  bit          mon_en = 1'b0;
  int          mon_cyc = 0;
  bit          mon_active = 1'b0;
  logic        ov_prev = 1'b0;

  // Hand-derived DES key-schedule rotation amounts per round index
  int enc_shift[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int dec_shift[16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [16:0] ev(input int cyc, input bit ld, input bit rd, input bit fn,
                                     input bit ov, input int idx, input int sh, input bit dir);
    return {6'(cyc), ld, rd, fn, ov, 4'(idx), 2'(sh), dir};
  endfunction

  // Monitor / scoreboard
  always @(negedge CLK) begin
    if (mon_en) begin
      if (mon_active) mon_cyc++;
      check("in_ready_vs_busy", {31'd0, IN_READY}, {31'd0, !BUSY});
      if (!BUSY) check("ks_dir_idle", {31'd0, KS_DIR}, 32'd0);
      if (!DP_ROUND) check("idx_shift_off_round", {26'd0, DP_ROUND_IDX, KS_SHIFT}, 32'd0);
      if (DP_LOAD || DP_ROUND || DP_FINAL || (OUT_VALID && !ov_prev)) begin
        mon_act = {6'(mon_cyc), DP_LOAD, DP_ROUND, DP_FINAL, OUT_VALID && !ov_prev,
                   DP_ROUND_IDX, KS_SHIFT, KS_DIR};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_event: got %h, none expected at %0t", mon_act, $time);
        end else begin
          check("event", {15'd0, mon_act}, {15'd0, exp_q.pop_front()});
        end
      end
      ov_prev = OUT_VALID;
      if (IN_VALID && IN_READY && !RST) begin
        mon_cyc    = 0;
        mon_active = 1'b1;
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!IN_READY && t < 50) begin
      tick();
      t++;
    end
    check("in_ready_timeout", {31'd0, IN_READY}, 32'd1);
  endtask

  task automatic wait_out();
    int t = 0;
    while (!OUT_VALID && t < 40) begin
      tick();
      t++;
    end
    check("out_valid_timeout", {31'd0, OUT_VALID}, 32'd1);
  endtask

  // abort_idx < 0: full block; otherwise RST is asserted while that round index is shown.
  task automatic send(input bit dec, input bit toggle, input int abort_idx);
    wait_ready();
    IN_VALID = 1'b1;
    DECRYPT  = dec;
    exp_q.push_back(ev(1, 1, 0, 0, 0, 0, 0, dec));
    for (int i = 0; i < ROUNDS; i++) begin
      if (abort_idx >= 0 && i > abort_idx) break;
      exp_q.push_back(ev(i + 2, 0, 1, 0, 0, i, dec ? dec_shift[i] : enc_shift[i], dec));
    end
    if (abort_idx < 0) begin
      exp_q.push_back(ev(ROUNDS + 2, 0, 0, 1, 0, 0, 0, dec));
      exp_q.push_back(ev(ROUNDS + 3, 0, 0, 0, 1, 0, 0, dec));
    end
    tick();
    IN_VALID = 1'b0;
    if (toggle) begin
      for (int k = 0; k <= ROUNDS; k++) begin
        DECRYPT = ~DECRYPT;
        tick();
      end
    end
    if (abort_idx >= 0) begin
      repeat (abort_idx + 1) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("abort_in_ready", {31'd0, IN_READY}, 32'd1);
      check("abort_busy", {31'd0, BUSY}, 32'd0);
      check("abort_out_valid", {31'd0, OUT_VALID}, 32'd0);
      check("abort_dp_final", {31'd0, DP_FINAL}, 32'd0);
      check("abort_queue_drained", exp_q.size(), 32'd0);
    end
  endtask

  task automatic expect_idle_after_consume();
    tick();
    check("consume_in_ready", {31'd0, IN_READY}, 32'd1);
    check("consume_out_valid", {31'd0, OUT_VALID}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; DECRYPT = 1'b0; OUT_READY = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    mon_en = 1'b1;

    // Idle after reset: only IN_READY high
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("rst_in_ready", {31'd0, IN_READY}, 32'd1);
      check("rst_outputs", {19'd0, BUSY, OUT_VALID, DP_LOAD, DP_ROUND, DP_FINAL, DP_ROUND_IDX,
                            KS_SHIFT, KS_DIR}, 32'd0);
      check("rst_state", {29'd0, DBG_STATE}, 32'd0);
    end
    tick();

    // Encrypt then decrypt, consumer always ready
    send(1'b0, 1'b0, -1);
    wait_out();
    expect_idle_after_consume();
    send(1'b1, 1'b0, -1);
    wait_out();
    expect_idle_after_consume();

    // Backpressure for 10 cycles
    OUT_READY = 1'b0;
    send(1'b0, 1'b0, -1);
    wait_out();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_valid", {31'd0, OUT_VALID}, 32'd1);
      check("bp_in_ready", {31'd0, IN_READY}, 32'd0);
      check("bp_state", {29'd0, DBG_STATE}, 32'd4);
    end
    OUT_READY = 1'b1;
    expect_idle_after_consume();

    // DECRYPT toggling while busy must not disturb the latched mode
    send(1'b1, 1'b1, -1);
    wait_out();
    expect_idle_after_consume();
    send(1'b0, 1'b1, -1);
    wait_out();
    expect_idle_after_consume();

    // Reset at round index 7, then a clean encrypt
    send(1'b0, 1'b0, 7);
    send(1'b0, 1'b0, -1);
    wait_out();
    expect_idle_after_consume();

    repeat (3) tick();
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
